// File: rtl/match_req_issuer_if.sv
// rtl/match_req_issuer_if.sv - candidate, match request/response and result channels of match_req_issuer
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 16
`endif
`ifndef NUM_JOB_PE_LOG2
`define NUM_JOB_PE_LOG2 2
`endif
`ifndef MAX_MATCH_LEN_LOG2
`define MAX_MATCH_LEN_LOG2 8
`endif

interface match_req_issuer_if;
    logic                           i_cand_valid;
    logic                           o_cand_ready;
    logic [`ADDR_WIDTH-1:0]         i_cand_head_addr;
    logic [`ADDR_WIDTH-1:0]         i_cand_history_addr;
    logic                           i_cand_last;

    logic                           o_match_req_valid;
    logic                           i_match_req_ready;
    logic [`NUM_JOB_PE_LOG2-1:0]    o_match_req_job_pe_id;
    logic [7:0]                     o_match_req_tag;
    logic [`ADDR_WIDTH-1:0]         o_match_req_head_addr;
    logic [`ADDR_WIDTH-1:0]         o_match_req_history_addr;

    logic                           i_match_resp_valid;
    logic                           o_match_resp_ready;
    logic [`NUM_JOB_PE_LOG2-1:0]    i_match_resp_job_pe_id;
    logic [7:0]                     i_match_resp_tag;
    logic [`MAX_MATCH_LEN_LOG2:0]   i_match_resp_match_len;

    logic                           o_res_valid;
    logic                           i_res_ready;
    logic [`ADDR_WIDTH-1:0]         o_res_head_addr;
    logic [`MAX_MATCH_LEN_LOG2:0]   o_res_match_len;
    logic [`ADDR_WIDTH-1:0]         o_res_history_addr;

    // Issuer side
    modport master (
        input  i_cand_valid, i_cand_head_addr, i_cand_history_addr, i_cand_last,
        output o_cand_ready,
        output o_match_req_valid, o_match_req_job_pe_id, o_match_req_tag,
        output o_match_req_head_addr, o_match_req_history_addr,
        input  i_match_req_ready,
        input  i_match_resp_valid, i_match_resp_job_pe_id, i_match_resp_tag, i_match_resp_match_len,
        output o_match_resp_ready,
        output o_res_valid, o_res_head_addr, o_res_match_len, o_res_history_addr,
        input  i_res_ready
    );

    // Surrounding fabric side
    modport slave (
        output i_cand_valid, i_cand_head_addr, i_cand_history_addr, i_cand_last,
        input  o_cand_ready,
        input  o_match_req_valid, o_match_req_job_pe_id, o_match_req_tag,
        input  o_match_req_head_addr, o_match_req_history_addr,
        output i_match_req_ready,
        output i_match_resp_valid, i_match_resp_job_pe_id, i_match_resp_tag, i_match_resp_match_len,
        input  o_match_resp_ready,
        input  o_res_valid, o_res_head_addr, o_res_match_len, o_res_history_addr,
        output i_res_ready
    );
endinterface

// File: rtl/match_req_issuer.sv
// rtl/match_req_issuer.sv - tags candidates, issues match requests, keeps best response per position (macro MATCH_ISSUER_TIE_NEAREST_EN)
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 16
`endif
`ifndef NUM_JOB_PE_LOG2
`define NUM_JOB_PE_LOG2 2
`endif
`ifndef MAX_MATCH_LEN_LOG2
`define MAX_MATCH_LEN_LOG2 8
`endif
`ifndef LOG
`define LOG(msg)
`endif

module match_req_issuer #(
    parameter int JOB_PE_IDX = 0,
    parameter int NUM_SLOTS  = 4,
    parameter int MAX_CAND   = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    match_req_issuer_if.master bus
);
    localparam int AW   = `ADDR_WIDTH;
    localparam int PW   = `NUM_JOB_PE_LOG2;
    localparam int LW   = `MAX_MATCH_LEN_LOG2 + 1;
    localparam int SW   = $clog2(NUM_SLOTS);
    localparam int CW   = $clog2(MAX_CAND);
    localparam int CNTW = CW + 1;
    localparam int NH   = NUM_SLOTS * MAX_CAND;

    localparam logic [PW-1:0]   PE_ID    = PW'(JOB_PE_IDX);
    localparam logic [CNTW-1:0] CNT_ONE  = CNTW'(1);
    localparam logic [CNTW-1:0] CNT_MAX  = CNTW'(MAX_CAND);
    localparam logic [SW-1:0]   SLOT_ONE = SW'(1);

    logic                 run;
    logic [NUM_SLOTS-1:0] occ;
    logic [NUM_SLOTS-1:0] closed;
    logic [AW-1:0]        slot_head [NUM_SLOTS];
    logic [CNTW-1:0]      issued    [NUM_SLOTS];
    logic [CNTW-1:0]      returned  [NUM_SLOTS];
    logic [LW-1:0]        best_len  [NUM_SLOTS];
    logic [AW-1:0]        best_hist [NUM_SLOTS];
    logic [AW-1:0]        cand_hist [NH];
    logic [SW-1:0]        hp;
    logic [SW-1:0]        tp;
    logic                 drop;

    logic                 req_valid;
    logic [7:0]           req_tag;
    logic [AW-1:0]        req_head;
    logic [AW-1:0]        req_hist;

    // Intake decode: a slot at tp is either free (new position), open (filling) or closed (ring full)
    logic            tp_free, tp_open, cand_ready, cand_take, issue, close_now;
    logic [CNTW-1:0] base_cnt, next_cnt;

    assign tp_free    = !occ[tp];
    assign tp_open    = occ[tp] && !closed[tp];
    assign cand_ready = run && (drop || ((!req_valid || bus.i_match_req_ready) && (tp_open || tp_free)));
    assign cand_take  = bus.i_cand_valid && cand_ready;
    assign issue      = cand_take && !drop;
    assign base_cnt   = tp_free ? '0 : issued[tp];
    assign next_cnt   = base_cnt + CNT_ONE;
    assign close_now  = bus.i_cand_last || (next_cnt == CNT_MAX);

    // Response decode: only responses addressed to a live slot of this PE are applied
    logic [SW-1:0] rs_slot;
    logic [CW-1:0] rs_idx;
    logic [AW-1:0] rs_hist;
    logic [LW-1:0] rs_len;
    logic          rs_hi_zero, resp_fire, resp_ok, resp_drop, resp_better;

    assign rs_slot    = bus.i_match_resp_tag[SW+CW-1:CW];
    assign rs_idx     = bus.i_match_resp_tag[CW-1:0];
    assign rs_hist    = cand_hist[{rs_slot, rs_idx}];
    assign rs_len     = bus.i_match_resp_match_len;
    assign rs_hi_zero = (bus.i_match_resp_tag >> (SW + CW)) == 8'd0;
    assign resp_fire  = bus.i_match_resp_valid && run;
    assign resp_ok    = resp_fire && (bus.i_match_resp_job_pe_id == PE_ID) && rs_hi_zero && occ[rs_slot];
    assign resp_drop  = resp_fire && !resp_ok;

`ifdef MATCH_ISSUER_TIE_NEAREST_EN
    // Equal lengths prefer the larger history address (nearest offset); zero length never carries an address
    assign resp_better = (rs_len > best_len[rs_slot]) ||
                         ((rs_len == best_len[rs_slot]) && (rs_len != '0) && (rs_hist > best_hist[rs_slot]));
`else
    assign resp_better = rs_len > best_len[rs_slot];
`endif

    // Retire the oldest position once every issued candidate has answered
    logic res_valid, retire;
    assign res_valid = occ[hp] && closed[hp] && (returned[hp] == issued[hp]);
    assign retire    = res_valid && bus.i_res_ready;

    // Slot ring, request register and drop-mode state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run       <= 1'b0;
            occ       <= '0;
            closed    <= '0;
            hp        <= '0;
            tp        <= '0;
            drop      <= 1'b0;
            req_valid <= 1'b0;
            req_tag   <= '0;
            req_head  <= '0;
            req_hist  <= '0;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                slot_head[i] <= '0;
                issued[i]    <= '0;
                returned[i]  <= '0;
                best_len[i]  <= '0;
                best_hist[i] <= '0;
            end
            for (int i = 0; i < NH; i++) begin
                cand_hist[i] <= '0;
            end
        end else begin
            run <= 1'b1;

            if (issue) begin
                req_valid <= 1'b1;
                req_tag   <= 8'({tp, base_cnt[CW-1:0]});
                req_head  <= tp_free ? bus.i_cand_head_addr : slot_head[tp];
                req_hist  <= bus.i_cand_history_addr;
            end else if (bus.i_match_req_ready) begin
                req_valid <= 1'b0;
            end

            if (cand_take) begin
                if (drop) begin
                    if (bus.i_cand_last) begin
                        drop <= 1'b0;
                    end
                end else begin
                    if (tp_free) begin
                        occ[tp]       <= 1'b1;
                        slot_head[tp] <= bus.i_cand_head_addr;
                        returned[tp]  <= '0;
                        best_len[tp]  <= '0;
                        best_hist[tp] <= '0;
                    end
                    issued[tp] <= next_cnt;
                    cand_hist[{tp, base_cnt[CW-1:0]}] <= bus.i_cand_history_addr;
                    if (close_now) begin
                        closed[tp] <= 1'b1;
                        tp         <= tp + SLOT_ONE;
                    end
                    if ((next_cnt == CNT_MAX) && !bus.i_cand_last) begin
                        drop <= 1'b1;
                    end
                end
            end

            if (resp_ok) begin
                returned[rs_slot] <= returned[rs_slot] + CNT_ONE;
                if (resp_better) begin
                    best_len[rs_slot]  <= rs_len;
                    best_hist[rs_slot] <= rs_hist;
                end
            end
            if (resp_drop) begin
                `LOG("match response dropped: foreign id, bad tag or free slot")
            end

            if (retire) begin
                occ[hp]    <= 1'b0;
                closed[hp] <= 1'b0;
                hp         <= hp + SLOT_ONE;
            end
        end
    end

    assign bus.o_cand_ready             = cand_ready;
    assign bus.o_match_req_valid        = req_valid;
    assign bus.o_match_req_job_pe_id    = PE_ID;
    assign bus.o_match_req_tag          = req_tag;
    assign bus.o_match_req_head_addr    = req_head;
    assign bus.o_match_req_history_addr = req_hist;
    assign bus.o_match_resp_ready       = run;
    assign bus.o_res_valid              = res_valid;
    assign bus.o_res_head_addr          = slot_head[hp];
    assign bus.o_res_match_len          = best_len[hp];
    assign bus.o_res_history_addr       = best_hist[hp];
endmodule

// File: tb/tb_match_req_issuer.sv
// tb/tb_match_req_issuer.sv - scoreboard bench for match_req_issuer
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 16
`endif
`ifndef NUM_JOB_PE_LOG2
`define NUM_JOB_PE_LOG2 2
`endif
`ifndef MAX_MATCH_LEN_LOG2
`define MAX_MATCH_LEN_LOG2 8
`endif

module tb_match_req_issuer;
    localparam int AW = `ADDR_WIDTH;
    localparam int PW = `NUM_JOB_PE_LOG2;
    localparam int LW = `MAX_MATCH_LEN_LOG2 + 1;

    typedef struct packed {
        logic [7:0]    tag;
        logic [AW-1:0] head;
        logic [AW-1:0] hist;
    } req_t;

    typedef struct packed {
        logic [AW-1:0] head;
        logic [LW-1:0] len;
        logic [AW-1:0] hist;
    } res_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;
    req_t req_q[$];
    res_t res_q[$];

    always #5 clk = ~clk;

    match_req_issuer_if bus();

    match_req_issuer #(.JOB_PE_IDX(0), .NUM_SLOTS(4), .MAX_CAND(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic exp_req(input logic [7:0] tag, input logic [AW-1:0] head, input logic [AW-1:0] hist);
        req_t e;
        e.tag = tag; e.head = head; e.hist = hist;
        req_q.push_back(e);
    endtask

    task automatic exp_res(input logic [AW-1:0] head, input logic [LW-1:0] len, input logic [AW-1:0] hist);
        res_t e;
        e.head = head; e.len = len; e.hist = hist;
        res_q.push_back(e);
    endtask

    task automatic settle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_cand(input logic [AW-1:0] head, input logic [AW-1:0] hist, input logic last);
        int   n;
        logic rdy;
        n = 0;
        bus.i_cand_valid        = 1'b1;
        bus.i_cand_head_addr    = head;
        bus.i_cand_history_addr = hist;
        bus.i_cand_last         = last;
        do begin
            @(negedge clk);
            rdy = bus.o_cand_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!rdy && n < 50);
        bus.i_cand_valid = 1'b0;
        if (!rdy) check("cand_accept_timeout", 32'(rdy), 32'd1);
    endtask

    task automatic send_resp(input logic [PW-1:0] id, input logic [7:0] tag, input logic [LW-1:0] len);
        bus.i_match_resp_valid     = 1'b1;
        bus.i_match_resp_job_pe_id = id;
        bus.i_match_resp_tag       = tag;
        bus.i_match_resp_match_len = len;
        @(posedge clk);
        #1;
        bus.i_match_resp_valid = 1'b0;
    endtask

    // Monitor: every request/result handshake pops the oldest expectation
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.o_match_req_valid && bus.i_match_req_ready) begin
                if (req_q.size() == 0) begin
                    check("req_unexpected", 32'(bus.o_match_req_tag), 32'hffff_ffff);
                end else begin
                    req_t e;
                    e = req_q.pop_front();
                    check("req_tag", 32'(bus.o_match_req_tag), 32'(e.tag));
                    check("req_head", 32'(bus.o_match_req_head_addr), 32'(e.head));
                    check("req_hist", 32'(bus.o_match_req_history_addr), 32'(e.hist));
                    check("req_pe_id", 32'(bus.o_match_req_job_pe_id), 32'd0);
                end
            end
            if (bus.o_res_valid && bus.i_res_ready) begin
                if (res_q.size() == 0) begin
                    check("res_unexpected", 32'(bus.o_res_head_addr), 32'hffff_ffff);
                end else begin
                    res_t e;
                    e = res_q.pop_front();
                    check("res_head", 32'(bus.o_res_head_addr), 32'(e.head));
                    check("res_len", 32'(bus.o_res_match_len), 32'(e.len));
                    check("res_hist", 32'(bus.o_res_history_addr), 32'(e.hist));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, vectors=%0d", vectors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.i_cand_valid           = 1'b0;
        bus.i_cand_head_addr       = '0;
        bus.i_cand_history_addr    = '0;
        bus.i_cand_last            = 1'b0;
        bus.i_match_req_ready      = 1'b1;
        bus.i_match_resp_valid     = 1'b0;
        bus.i_match_resp_job_pe_id = '0;
        bus.i_match_resp_tag       = '0;
        bus.i_match_resp_match_len = '0;
        bus.i_res_ready            = 1'b1;

        // Reset state
        settle(2);
        check("rst_cand_ready", 32'(bus.o_cand_ready), 32'd0);
        check("rst_req_valid", 32'(bus.o_match_req_valid), 32'd0);
        check("rst_resp_ready", 32'(bus.o_match_resp_ready), 32'd0);
        check("rst_res_valid", 32'(bus.o_res_valid), 32'd0);
        check("rst_req_tag", 32'(bus.o_match_req_tag), 32'd0);
        check("rst_res_len", 32'(bus.o_res_match_len), 32'd0);
        rst_n = 1'b1;
        settle(1);
        check("run_resp_ready", 32'(bus.o_match_resp_ready), 32'd1);
        check("run_cand_ready", 32'(bus.o_cand_ready), 32'd1);

        // One position, two candidates, longer match wins (slot 0)
        exp_req(8'h00, 16'h1000, 16'h0100);
        exp_req(8'h01, 16'h1000, 16'h0180);
        exp_res(16'h1000, 9'd7, 16'h0180);
        send_cand(16'h1000, 16'h0100, 1'b0);
        send_cand(16'h1000, 16'h0180, 1'b1);
        settle(2);
        send_resp(2'd0, 8'h00, 9'd5);
        check("t1_partial_res_valid", 32'(bus.o_res_valid), 32'd0);
        send_resp(2'd0, 8'h01, 9'd7);
        settle(3);

        // Six candidates, closes by count, last two swallowed (slot 1)
        exp_req(8'h04, 16'h2000, 16'h0300);
        exp_req(8'h05, 16'h2000, 16'h0310);
        exp_req(8'h06, 16'h2000, 16'h0320);
        exp_req(8'h07, 16'h2000, 16'h0330);
        exp_res(16'h2000, 9'd8, 16'h0310);
        for (int i = 0; i < 6; i++) begin
            send_cand(16'h2000, 16'h0300 + 16'(i * 16), (i == 5) ? 1'b1 : 1'b0);
        end
        settle(2);
        send_resp(2'd0, 8'h04, 9'd3);
        send_resp(2'd0, 8'h05, 9'd8);
        send_resp(2'd0, 8'h06, 9'd2);
        settle(1);
        check("t2_three_of_four_res_valid", 32'(bus.o_res_valid), 32'd0);
        send_resp(2'd0, 8'h07, 9'd6);
        settle(3);

        // Foreign id, free slot and nonzero upper tag bits are ignored (slot 2)
        exp_req(8'h08, 16'h3000, 16'h0400);
        exp_res(16'h3000, 9'd4, 16'h0400);
        send_cand(16'h3000, 16'h0400, 1'b1);
        settle(2);
        send_resp(2'd1, 8'h08, 9'd20);
        send_resp(2'd0, 8'h0C, 9'd20);
        send_resp(2'd0, 8'h48, 9'd20);
        settle(1);
        check("t4_ignored_res_valid", 32'(bus.o_res_valid), 32'd0);
        send_resp(2'd0, 8'h08, 9'd4);
        settle(3);

        // Equal lengths (slot 3)
        exp_req(8'h0C, 16'h4000, 16'h0200);
        exp_req(8'h0D, 16'h4000, 16'h0240);
`ifdef MATCH_ISSUER_TIE_NEAREST_EN
        exp_res(16'h4000, 9'd9, 16'h0240);
`else
        exp_res(16'h4000, 9'd9, 16'h0200);
`endif
        send_cand(16'h4000, 16'h0200, 1'b0);
        send_cand(16'h4000, 16'h0240, 1'b1);
        settle(2);
        send_resp(2'd0, 8'h0C, 9'd9);
        send_resp(2'd0, 8'h0D, 9'd9);
        settle(3);

        // Four positions in flight, reverse responses, fifth position waits for a free slot
        for (int k = 0; k < 4; k++) begin
            exp_req(8'(k * 4), 16'h5000 + 16'(k * 256), 16'h0600 + 16'(k * 16));
        end
        exp_res(16'h5000, 9'd4, 16'h0600);
        exp_res(16'h5100, 9'd3, 16'h0610);
        exp_res(16'h5200, 9'd2, 16'h0620);
        exp_res(16'h5300, 9'd1, 16'h0630);
        exp_req(8'h00, 16'h9000, 16'h0700);
        exp_res(16'h9000, 9'd0, 16'h0000);
        for (int k = 0; k < 4; k++) begin
            send_cand(16'h5000 + 16'(k * 256), 16'h0600 + 16'(k * 16), 1'b1);
        end
        bus.i_cand_valid        = 1'b1;
        bus.i_cand_head_addr    = 16'h9000;
        bus.i_cand_history_addr = 16'h0700;
        bus.i_cand_last         = 1'b1;
        settle(2);
        check("t3_full_cand_ready", 32'(bus.o_cand_ready), 32'd0);
        send_resp(2'd0, 8'h0C, 9'd1);
        send_resp(2'd0, 8'h08, 9'd2);
        send_resp(2'd0, 8'h04, 9'd3);
        check("t3_hp_pending_res_valid", 32'(bus.o_res_valid), 32'd0);
        check("t3_still_full_cand_ready", 32'(bus.o_cand_ready), 32'd0);
        send_resp(2'd0, 8'h00, 9'd4);
        check("t3_retire_cycle_res_valid", 32'(bus.o_res_valid), 32'd1);
        check("t3_retire_cycle_cand_ready", 32'(bus.o_cand_ready), 32'd0);
        settle(1);
        check("t3_after_retire_cand_ready", 32'(bus.o_cand_ready), 32'd1);
        settle(1);
        bus.i_cand_valid = 1'b0;
        settle(4);
        send_resp(2'd0, 8'h00, 9'd0);
        settle(3);

        // Reset mid-burst with the request register stalled (slot 1 in use)
        bus.i_match_req_ready = 1'b0;
        send_cand(16'hA000, 16'h0800, 1'b0);
        check("rb_req_valid", 32'(bus.o_match_req_valid), 32'd1);
        check("rb_req_tag", 32'(bus.o_match_req_tag), 32'h04);
        bus.i_cand_valid        = 1'b1;
        bus.i_cand_history_addr = 16'h0810;
        #1;
        check("rb_stalled_cand_ready", 32'(bus.o_cand_ready), 32'd0);
        #1;
        rst_n = 1'b0;
        #1;
        check("rb_cand_ready", 32'(bus.o_cand_ready), 32'd0);
        check("rb_req_valid_cleared", 32'(bus.o_match_req_valid), 32'd0);
        check("rb_req_hist", 32'(bus.o_match_req_history_addr), 32'd0);
        check("rb_resp_ready", 32'(bus.o_match_resp_ready), 32'd0);
        check("rb_res_valid", 32'(bus.o_res_valid), 32'd0);
        bus.i_cand_valid      = 1'b0;
        bus.i_match_req_ready = 1'b1;
        settle(2);
        rst_n = 1'b1;
        settle(2);
        send_resp(2'd0, 8'h04, 9'd9);
        settle(1);
        check("rb_stale_res_valid", 32'(bus.o_res_valid), 32'd0);
        exp_req(8'h00, 16'hB000, 16'h0900);
        exp_res(16'hB000, 9'd6, 16'h0900);
        send_cand(16'hB000, 16'h0900, 1'b1);
        settle(2);
        send_resp(2'd0, 8'h00, 9'd6);
        settle(5);

        check("req_queue_drained", 32'(req_q.size()), 32'd0);
        check("res_queue_drained", 32'(res_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/match_req_issuer.md
# match_req_issuer

Job-PE-side initiator of the match request/response protocol. It accepts hash-chain candidates grouped per head position, tags them, and issues them to the match-PE fabric. It collects out-of-order match responses by tag, keeps the longest match per position, and retires position results in arrival order. One instance sits in each job PE, between candidate fetch and the sequence/literal encoder.

## Interface
Parameters:
- JOB_PE_IDX, 0: this job PE's id; driven on every request, checked on every response.
- NUM_SLOTS, 4: head positions in flight; power of 2.
- MAX_CAND, 4: candidates issued per position; power of 2; NUM_SLOTS*MAX_CAND ≤ 256.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
  - clk  in  1  clock.
  - rst_n  in  1  asynchronous active-low reset.
- Candidate input:
  - i_cand_valid  in  1  candidate present.
  - o_cand_ready  out  1  candidate accepted when valid&ready.
  - i_cand_head_addr  in  `ADDR_WIDTH  head position; sampled on the first candidate of a position.
  - i_cand_history_addr  in  `ADDR_WIDTH  candidate history address.
  - i_cand_last  in  1  last candidate of this position.
- Match request output:
  - o_match_req_valid  out  1  request valid.
  - i_match_req_ready  in  1  request accepted.
  - o_match_req_job_pe_id  out  `NUM_JOB_PE_LOG2  constant JOB_PE_IDX.
  - o_match_req_tag  out  8  {zeros, slot, cand_idx}.
  - o_match_req_head_addr  out  `ADDR_WIDTH  head address.
  - o_match_req_history_addr  out  `ADDR_WIDTH  history address.
- Match response input:
  - i_match_resp_valid  in  1  response valid.
  - o_match_resp_ready  out  1  constant 1 out of reset.
  - i_match_resp_job_pe_id  in  `NUM_JOB_PE_LOG2  response owner.
  - i_match_resp_tag  in  8  returned tag.
  - i_match_resp_match_len  in  `MAX_MATCH_LEN_LOG2+1  match length.
- Result output:
  - o_res_valid  out  1  oldest position complete.
  - i_res_ready  in  1  result consumed.
  - o_res_head_addr  out  `ADDR_WIDTH  position.
  - o_res_match_len  out  `MAX_MATCH_LEN_LOG2+1  best length (0 = none).
  - o_res_history_addr  out  `ADDR_WIDTH  best candidate address (0 when len 0).

## Operation
- Slots form a ring with head pointer hp (oldest) and tail pointer tp (filling). Each slot holds: occupied, closed, head_addr, issued count, returned count, best_len, best_hist.
- Tag = {slot, cand_idx}. cand_idx equals the slot's issued count at issue time. Unused upper tag bits are 0.
- Intake:
  - The first candidate of a position needs slot tp to be free.
  - That candidate sets occupied, latches head_addr, and zeroes the counts and best fields.
  - Each accepted candidate loads the request register and increments issued.
  - The slot closes and tp advances when i_cand_last is accepted, or when issued reaches MAX_CAND.
  - Drop mode: if the slot closes by count without last, following candidates are accepted and discarded (no request) until last is accepted.
- o_cand_ready = drop mode OR ((request register empty OR i_match_req_ready) AND (slot tp open, or slot tp free)).
- Response handling, applied only when all of the following hold:
  - i_match_resp_job_pe_id == JOB_PE_IDX;
  - tag upper bits are 0;
  - the tagged slot is occupied.
  Otherwise the response is dropped and raises a `LOG warning.
- A valid response increments returned. It replaces best when match_len > best_len (ties: see Configuration).
- Retire: o_res_valid = slot hp occupied AND closed AND returned == issued. On handshake the slot is freed and hp advances.
- Arithmetic: counts are $clog2(MAX_CAND)+1 bits. Length compare is unsigned at full width.

## Timing
- Reset: o_cand_ready=0, o_match_req_valid=0, o_match_resp_ready=0, o_res_valid=0; all data outputs and slot state 0. Reset mid-operation discards every outstanding request; late responses are then dropped as unoccupied.
- Candidate accepted at cycle N → o_match_req_valid at N+1. The request is held stable until ready. One-deep register; back-to-back issue at full rate.
- Response accepted at cycle M → slot updated at M+1 → o_res_valid at M+1 at the earliest. The result is combinational from slot hp registers and is held until ready.
- A freed slot is reusable from the cycle after the retire handshake, never in the same cycle.
- Final response and intake close in the same cycle: both apply; valid the next cycle.
- Full: all slots occupied → o_cand_ready=0 for the first candidate of a new position.

## Configuration
- MATCH_ISSUER_TIE_NEAREST_EN:
  - Defined: an equal match_len with a larger history_addr replaces best (nearest offset).
  - Undefined: ties keep the earliest-arrived response.

## Test plan
- One position, 2 candidates (hist 0x100, 0x180), responses len 5 then 7 → tags 0x00, 0x01; result len 7, hist 0x180.
- 6 candidates with last on the 6th, MAX_CAND=4 → exactly 4 requests, candidates 5–6 accepted silently, result after 4 responses.
- 4 positions outstanding, responses returned in reverse slot order → results emitted slot 0,1,2,3; 5th position stalled until the first retire completes, then allocated the following cycle.
- Response with wrong job_pe_id or unoccupied tag → ignored; returned count and result unchanged.
- Tie: len 9 at hist 0x200, then len 9 at hist 0x240 → hist 0x240 with the macro defined, 0x200 without.
- Assert rst_n mid-burst with i_match_req_ready=0 → all outputs 0 immediately; stale response after release is dropped; a fresh position issues tag 0x00.
